// File: rtl/ctrl_pkg.sv
// Control-bundle encoding shared by the pipeline control path: field positions,
// stage-register layouts, bubble constants and ALU/forwarding select encodings.
package ctrl_pkg;

  localparam int unsigned WB_W  = 2;
  localparam int unsigned M_W   = 3;
  localparam int unsigned EXE_W = 4;
  localparam int unsigned REG_W = 5;

  localparam int unsigned WB_REGWRITE  = 1;
  localparam int unsigned WB_MEMTOREG  = 0;
  localparam int unsigned M_BRANCH     = 2;
  localparam int unsigned M_MEMREAD    = 1;
  localparam int unsigned M_MEMWRITE   = 0;
  localparam int unsigned EXE_REGDST   = 3;
  localparam int unsigned EXE_ALUOP_HI = 2;
  localparam int unsigned EXE_ALUOP_LO = 1;
  localparam int unsigned EXE_ALUSRC   = 0;

  typedef logic [WB_W-1:0]  wb_t;
  typedef logic [M_W-1:0]   m_t;
  typedef logic [EXE_W-1:0] exe_t;
  typedef logic [REG_W-1:0] reg_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_e;

  typedef struct packed {
    wb_t  wb;
    m_t   m;
    exe_t exe;
    reg_t rs;
    reg_t rt;
    reg_t rd;
  } idex_t;

  typedef struct packed {
    wb_t  wb;
    m_t   m;
    reg_t dest;
    logic zero;
  } exmem_t;

  typedef struct packed {
    wb_t  wb;
    reg_t dest;
  } memwb_t;

  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

  // EX/MEM is the younger result, so it is tested first.
  function automatic fwd_e fwd_select(
    input reg_t src,
    input logic exmem_rw,
    input reg_t exmem_dest,
    input logic memwb_rw,
    input reg_t memwb_dest
  );
    if (exmem_rw && exmem_dest != '0 && exmem_dest == src)
      return FWD_EXMEM;
    else if (memwb_rw && memwb_dest != '0 && memwb_dest == src)
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use stall detection and EX operand forwarding selects.
module hazard_fwd_unit
  import ctrl_pkg::*;
(
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             exmem_regwrite,
  input  logic [REG_W-1:0] exmem_dest,
  input  logic             memwb_regwrite,
  input  logic [REG_W-1:0] memwb_dest,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  always_comb begin
    stall = 1'b0;
    // A taken branch discards the ID instruction, so it never needs to wait.
    if (!flush && idex_memread && idex_rt != '0 &&
        (idex_rt == id_rs || idex_rt == id_rt))
      stall = 1'b1;

    fwd_a = fwd_select(idex_rs, exmem_regwrite, exmem_dest, memwb_regwrite, memwb_dest);
    fwd_b = fwd_select(idex_rt, exmem_regwrite, exmem_dest, memwb_regwrite, memwb_dest);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control pipeline registers with per-stage strobe
// decode, branch-taken flush and the hazard/forwarding unit.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WB_W-1:0]  id_wb,
  input  logic [M_W-1:0]   id_m,
  input  logic [EXE_W-1:0] id_exe,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_zero,
  output logic             ex_regdst,
  output logic [1:0]       ex_aluop,
  output logic             ex_alusrc,
  output logic [REG_W-1:0] ex_dest,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_branch,
  output logic             pc_src,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] wb_dest,
  output logic             stall,
  output logic             if_flush
);

  idex_t  idex,  idex_next;
  exmem_t exmem, exmem_next;
  memwb_t memwb, memwb_next;

  assign ex_regdst    = idex.exe[EXE_REGDST];
  assign ex_aluop     = aluop_e'(idex.exe[EXE_ALUOP_HI:EXE_ALUOP_LO]);
  assign ex_alusrc    = idex.exe[EXE_ALUSRC];
  assign ex_dest      = idex.exe[EXE_REGDST] ? idex.rd : idex.rt;

  assign mem_memread  = exmem.m[M_MEMREAD];
  assign mem_memwrite = exmem.m[M_MEMWRITE];
  assign mem_branch   = exmem.m[M_BRANCH];
  assign pc_src       = exmem.m[M_BRANCH] & exmem.zero;
  assign if_flush     = pc_src;

  assign wb_regwrite  = memwb.wb[WB_REGWRITE];
  assign wb_memtoreg  = memwb.wb[WB_MEMTOREG];
  assign wb_dest      = memwb.dest;

  hazard_fwd_unit u_hazard_fwd (
    .idex_memread   (idex.m[M_MEMREAD]),
    .idex_rs        (idex.rs),
    .idex_rt        (idex.rt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .exmem_regwrite (exmem.wb[WB_REGWRITE]),
    .exmem_dest     (exmem.dest),
    .memwb_regwrite (memwb.wb[WB_REGWRITE]),
    .memwb_dest     (memwb.dest),
    .flush          (pc_src),
    .stall          (stall),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  // A taken branch kills both younger instructions (ID and EX); a load-use
  // stall only inserts a bubble ahead of the waiting ID instruction.
  always_comb begin
    idex_next = {id_wb, id_m, id_exe, id_rs, id_rt, id_rd};
    if (pc_src || stall)
      idex_next = IDEX_BUBBLE;

    exmem_next = {idex.wb, idex.m, ex_dest, ex_zero};
    if (pc_src)
      exmem_next = EXMEM_BUBBLE;

    memwb_next = {exmem.wb, exmem.dest};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex  <= IDEX_BUBBLE;
      exmem <= EXMEM_BUBBLE;
      memwb <= MEMWB_BUBBLE;
    end else begin
      idex  <= idex_next;
      exmem <= exmem_next;
      memwb <= memwb_next;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: instruction-level pipeline model predicts the
// outputs of every cycle; a negedge monitor compares them against the DUT.
module tb_ctrl_pipe;

  logic       clk = 1'b1;
  logic       rst;
  logic [1:0] id_wb;
  logic [2:0] id_m;
  logic [3:0] id_exe;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_zero;
  logic       ex_regdst, ex_alusrc;
  logic [1:0] ex_aluop;
  logic [4:0] ex_dest;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_memread, mem_memwrite, mem_branch, pc_src;
  logic       wb_regwrite, wb_memtoreg;
  logic [4:0] wb_dest;
  logic       stall, if_flush;

  ctrl_pipe dut (
    .clk(clk), .rst(rst),
    .id_wb(id_wb), .id_m(id_m), .id_exe(id_exe),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .ex_regdst(ex_regdst), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_dest(ex_dest),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_branch(mem_branch),
    .pc_src(pc_src),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_dest(wb_dest),
    .stall(stall), .if_flush(if_flush)
  );

  always #5 clk = ~clk;

  typedef enum int { K_NOP, K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_UNK } kind_e;

  typedef struct packed {
    logic       regwrite, memtoreg, branch, memread, memwrite, regdst;
    logic [1:0] aluop;
    logic       alusrc;
    logic [4:0] rs, rt, rd, dest;
    logic       zero;
  } ins_t;

  typedef struct packed {
    logic       ex_regdst;
    logic [1:0] ex_aluop;
    logic       ex_alusrc;
    logic [4:0] ex_dest;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_memread, mem_memwrite, mem_branch, pc_src;
    logic       wb_regwrite, wb_memtoreg;
    logic [4:0] wb_dest;
    logic       stall, if_flush;
  } obs_t;

  ins_t s_ex, s_mem, s_wb;
  ins_t cur_in;
  logic cur_zero, cur_rst, last_stall;
  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  function automatic ins_t mk(input kind_e k, input int rs, input int rt, input int rd);
    ins_t i;
    i = '0;
    case (k)
      K_R:          begin i.regwrite = 1; i.regdst = 1; i.aluop = 2'b10; end
      K_LW:         begin i.regwrite = 1; i.memtoreg = 1; i.memread = 1; i.alusrc = 1; end
      K_SW:         begin i.memwrite = 1; i.alusrc = 1; end
      K_BEQ, K_UNK: begin i.branch = 1; i.aluop = 2'b01; end
      K_ADDI:       begin i.regwrite = 1; i.alusrc = 1; end
      default:      ;
    endcase
    i.rs = rs[4:0];
    i.rt = rt[4:0];
    i.rd = rd[4:0];
    return i;
  endfunction

  function automatic logic [8:0] enc(input ins_t i);
    return {i.regwrite, i.memtoreg, i.branch, i.memread, i.memwrite,
            i.regdst, i.aluop, i.alusrc};
  endfunction

  function automatic logic taken();
    return s_mem.branch && s_mem.zero;
  endfunction

  function automatic logic load_use();
    return !taken() && s_ex.memread && s_ex.rt != 0 &&
           (s_ex.rt == cur_in.rs || s_ex.rt == cur_in.rt);
  endfunction

  // Most recent in-flight writer of r wins; MEM is younger than WB.
  function automatic logic [1:0] fwd_for(input logic [4:0] r);
    ins_t older [2];
    older[0] = s_mem;
    older[1] = s_wb;
    for (int i = 0; i < 2; i++)
      if (older[i].regwrite && older[i].dest != 0 && older[i].dest == r)
        return (i == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic obs_t predict();
    obs_t o;
    o.ex_regdst    = s_ex.regdst;
    o.ex_aluop     = s_ex.aluop;
    o.ex_alusrc    = s_ex.alusrc;
    o.ex_dest      = s_ex.regdst ? s_ex.rd : s_ex.rt;
    o.fwd_a        = fwd_for(s_ex.rs);
    o.fwd_b        = fwd_for(s_ex.rt);
    o.mem_memread  = s_mem.memread;
    o.mem_memwrite = s_mem.memwrite;
    o.mem_branch   = s_mem.branch;
    o.pc_src       = taken();
    o.if_flush     = taken();
    o.wb_regwrite  = s_wb.regwrite;
    o.wb_memtoreg  = s_wb.memtoreg;
    o.wb_dest      = s_wb.dest;
    o.stall        = load_use();
    return o;
  endfunction

  function automatic obs_t sample();
    return {ex_regdst, ex_aluop, ex_alusrc, ex_dest, fwd_a, fwd_b,
            mem_memread, mem_memwrite, mem_branch, pc_src,
            wb_regwrite, wb_memtoreg, wb_dest, stall, if_flush};
  endfunction

  task automatic clear_model();
    s_ex = '0; s_mem = '0; s_wb = '0;
  endtask

  task automatic model_edge();
    logic fl, lu;
    if (cur_rst) begin
      clear_model();
    end else begin
      fl = taken();
      lu = load_use();
      s_wb = s_mem;
      if (fl) s_mem = '0;
      else begin
        s_mem      = s_ex;
        s_mem.dest = s_ex.regdst ? s_ex.rd : s_ex.rt;
        s_mem.zero = cur_zero;
      end
      s_ex = (fl || lu) ? '0 : cur_in;
    end
  endtask

  task automatic push_expect();
    obs_t e;
    e = predict();
    exp_q.push_back(e);
    last_stall = e.stall;
  endtask

  task automatic step(input ins_t in, input logic z, input logic r);
    @(posedge clk);
    model_edge();
    #1;
    rst     = r;
    cur_rst = r;
    if (r) clear_model();
    cur_in   = in;
    cur_zero = z;
    {id_wb, id_m, id_exe} = enc(in);
    id_rs   = in.rs;
    id_rt   = in.rt;
    id_rd   = in.rd;
    ex_zero = z;
    push_expect();
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        obs_t e, a;
        e = exp_q.pop_front();
        a = sample();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cycle %0d outputs: got %h expected %h", cyc, a, e);
        end
      end
    end
  end

  initial begin
    ins_t prev, nxt;
    rst = 1'b1; cur_rst = 1'b1;
    clear_model();
    cur_in = '0; cur_zero = 1'b0;
    {id_wb, id_m, id_exe} = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; ex_zero = 1'b0;
    #1;
    push_expect();
    chk("reset stall", stall, 0);
    chk("reset wb_dest", wb_dest, 0);
    step(mk(K_NOP, 0, 0, 0), 0, 0);

    // R-type flow
    step(mk(K_R, 1, 2, 5), 0, 0);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    #1;
    chk("rtype ex_regdst", ex_regdst, 1);
    chk("rtype ex_aluop", ex_aluop, 2);
    chk("rtype ex_dest", ex_dest, 5);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    #1;
    chk("rtype wb_regwrite", wb_regwrite, 1);
    chk("rtype wb_memtoreg", wb_memtoreg, 0);
    chk("rtype wb_dest", wb_dest, 5);

    // forwarding priority, then register 0 never forwards
    step(mk(K_R, 1, 2, 3), 0, 0);
    step(mk(K_R, 1, 2, 3), 0, 0);
    step(mk(K_R, 3, 3, 4), 0, 0);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    #1;
    chk("fwd priority a", fwd_a, 2);
    chk("fwd priority b", fwd_b, 2);
    step(mk(K_R, 1, 2, 0), 0, 0);
    step(mk(K_R, 1, 2, 0), 0, 0);
    step(mk(K_R, 3, 3, 4), 0, 0);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    #1;
    chk("fwd r0 a", fwd_a, 0);
    chk("fwd r0 b", fwd_b, 0);

    // load-use stall
    step(mk(K_LW, 1, 8, 0), 0, 0);
    step(mk(K_R, 8, 2, 9), 0, 0);
    #1;
    chk("loaduse stall", stall, 1);
    step(mk(K_R, 8, 2, 9), 0, 0);
    #1;
    chk("loaduse released", stall, 0);
    chk("loaduse bubble regdst", ex_regdst, 0);
    chk("loaduse bubble alusrc", ex_alusrc, 0);
    chk("loaduse bubble dest", ex_dest, 0);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    #1;
    chk("loaduse ex_dest", ex_dest, 9);
    chk("loaduse fwd_a memwb", fwd_a, 1);

    // BEQ taken
    step(mk(K_BEQ, 1, 2, 0), 0, 0);
    step(mk(K_R, 1, 2, 6), 1, 0);
    step(mk(K_R, 1, 2, 7), 0, 0);
    #1;
    chk("beq mem_branch", mem_branch, 1);
    chk("beq pc_src", pc_src, 1);
    chk("beq if_flush", if_flush, 1);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    #1;
    chk("beq flushed ex_regdst", ex_regdst, 0);
    chk("beq flushed mem_branch", mem_branch, 0);

    // flush and load-use together
    step(mk(K_UNK, 1, 2, 0), 0, 0);
    step(mk(K_LW, 1, 8, 0), 1, 0);
    step(mk(K_R, 8, 2, 9), 0, 0);
    #1;
    chk("flush+stall stall", stall, 0);
    chk("flush+stall if_flush", if_flush, 1);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    #1;
    chk("flush+stall ex_regdst", ex_regdst, 0);
    chk("flush+stall mem_memread", mem_memread, 0);

    // reset mid-operation
    step(mk(K_LW, 1, 9, 0), 0, 0);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    #1;
    chk("pre-reset mem_memread", mem_memread, 1);
    step(mk(K_NOP, 0, 0, 0), 0, 1);
    #1;
    chk("mid reset mem_memread", mem_memread, 0);
    step(mk(K_R, 1, 2, 12), 0, 0);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    step(mk(K_NOP, 0, 0, 0), 0, 0);
    #1;
    chk("post-reset wb_dest", wb_dest, 12);
    chk("post-reset wb_regwrite", wb_regwrite, 1);

    // randomized traffic; upstream holds ID while stalled
    prev = '0;
    for (int n = 0; n < 400; n++) begin
      if (last_stall)
        nxt = prev;
      else
        nxt = mk(kind_e'($urandom_range(0, 6)), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7));
      step(nxt, 1'($urandom_range(0, 1)), $urandom_range(0, 60) == 0);
      prev = nxt;
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
